// File: rtl/icache_responder.sv
// Direct-mapped, one-word-block instruction cache on the datapath fetch port.
// Hits answer combinationally in the request cycle; misses are filled from RAM
// through a two-state FSM (idle / fill). Fill data is written to the array only,
// so the original request hits in the first idle cycle after the fill.
module icache_responder #(
  parameter int unsigned SETS = 16
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        halt,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
);

  localparam int unsigned IDX  = $clog2(SETS);
  localparam int unsigned TAGW = 32 - IDX - 2;

  typedef enum logic [0:0] {
    StIdle,
    StFill
  } state_e;

  state_e state_q, state_d;

  // Line storage
  logic [SETS-1:0] valid_q;
  logic [TAGW-1:0] tag_q  [SETS];
  logic [31:0]     data_q [SETS];

  logic [31:0] miss_addr_q, miss_addr_d;
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;

  logic [IDX-1:0]  req_idx;
  logic [TAGW-1:0] req_tag;
  logic [IDX-1:0]  fill_idx;
  logic [TAGW-1:0] fill_tag;
  logic            lookup_hit;
  logic            fill_we;

  // Byte offset of the request never selects anything: blocks are one word.
  logic unused_byte_offset;
  assign unused_byte_offset = ^imemaddr[1:0];

  assign req_idx  = imemaddr[IDX+1:2];
  assign req_tag  = imemaddr[31:IDX+2];
  assign fill_idx = miss_addr_q[IDX+1:2];
  assign fill_tag = miss_addr_q[31:IDX+2];

  // Tag lookup for the current request; halt suppresses hits entirely.
  always_comb begin
    lookup_hit = 1'b0;
    if (imemREN && !halt && valid_q[req_idx] && (tag_q[req_idx] == req_tag)) begin
      lookup_hit = 1'b1;
    end
  end

  // FSM next-state, counters and port outputs.
  always_comb begin
    state_d     = state_q;
    miss_addr_d = miss_addr_q;
    hit_cnt_d   = hit_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    fill_we     = 1'b0;
    ihit        = 1'b0;
    imemload    = 32'h0;
    iREN        = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (lookup_hit) begin
          ihit      = 1'b1;
          imemload  = data_q[req_idx];
          hit_cnt_d = hit_cnt_q + 32'd1;
        end else if (imemREN && !halt) begin
          miss_addr_d = {imemaddr[31:2], 2'b00};
          miss_cnt_d  = miss_cnt_q + 32'd1;
          state_d     = StFill;
        end
      end
      StFill: begin
        // The fill runs to completion regardless of imemREN/imemaddr/halt.
        iREN = 1'b1;
        if (!iwait) begin
          fill_we = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // miss_addr_q only changes when leaving idle, so iaddr stays stable during a fill.
  assign iaddr    = miss_addr_q;
  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;

  // FSM state, fill address and counters.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= StIdle;
      miss_addr_q <= 32'h0;
      hit_cnt_q   <= 32'h0;
      miss_cnt_q  <= 32'h0;
    end else begin
      state_q     <= state_d;
      miss_addr_q <= miss_addr_d;
      hit_cnt_q   <= hit_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
    end
  end

  // Line array; a completed fill evicts whatever occupied the index.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      valid_q <= '0;
      for (int i = 0; i < int'(SETS); i++) begin
        tag_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else if (fill_we) begin
      valid_q[fill_idx] <= 1'b1;
      tag_q[fill_idx]   <= fill_tag;
      data_q[fill_idx]  <= iload;
    end
  end

endmodule
